// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and sync decoder types
package vga_pkg;

    localparam int HACTIVE = 640;
    localparam int HFP     = 16;
    localparam int HSYN    = 96;
    localparam int HBP     = 48;
    localparam int VACTIVE = 480;
    localparam int VFP     = 11;
    localparam int VSYN    = 2;
    localparam int VBP     = 32;
    localparam int HMAX    = HACTIVE + HFP + HSYN + HBP;
    localparam int VMAX    = VACTIVE + VFP + VSYN + VBP;

    // Line/frame length counters stick here once the sync source goes quiet
    localparam logic [9:0] LEN_SAT = 10'd1023;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    function automatic logic [9:0] len_inc(input logic [9:0] v);
        return (v == LEN_SAT) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop sync sampler with falling-edge pulse
module sync_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    // Shift the sync level through two stages
    always_comb begin
        s1_d = din;
        s2_d = s1_q;
    end

    // History resets to idle-high so no edge is seen right after reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign fall = s2_q & ~s1_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - recovers pixel coordinates and timing lock from VGA sync
module vga_sync_decoder #(
    parameter int HACTIVE     = vga_pkg::HACTIVE,
    parameter int HFP         = vga_pkg::HFP,
    parameter int HSYN        = vga_pkg::HSYN,
    parameter int HBP         = vga_pkg::HBP,
    parameter int VACTIVE     = vga_pkg::VACTIVE,
    parameter int VFP         = vga_pkg::VFP,
    parameter int VSYN        = vga_pkg::VSYN,
    parameter int VBP         = vga_pkg::VBP,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       vgaclk,
    input  logic       reset_n,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       blank_b,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [7:0] pr,
    output logic [7:0] pg,
    output logic [7:0] pb,
    output logic       pixel_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       timing_err,
    output logic [7:0] err_count
);

    import vga_pkg::*;

    localparam logic [9:0] H_LEN  = 10'(HACTIVE + HFP + HSYN + HBP);
    localparam logic [9:0] V_LEN  = 10'(VACTIVE + VFP + VSYN + VBP);
    localparam logic [9:0] X_REF  = 10'(HACTIVE + HFP);
    localparam logic [9:0] Y_REF  = 10'(VACTIVE + VFP);
    localparam logic [9:0] X_LAST = H_LEN - 10'd1;
    localparam logic [9:0] Y_LAST = V_LEN - 10'd1;
    localparam logic [9:0] H_ACT  = 10'(HACTIVE);
    localparam logic [9:0] V_ACT  = 10'(VACTIVE);
    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    logic h_fall, v_fall;

    sync_edge_det u_hs_edge (.clk(vgaclk), .reset_n(reset_n), .din(hsync), .fall(h_fall));
    sync_edge_det u_vs_edge (.clk(vgaclk), .reset_n(reset_n), .din(vsync), .fall(v_fall));

    sync_state_t state_q, state_d;
    logic [7:0]  r_s1_q, g_s1_q, b_s1_q;
    logic        blank_s1_q;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [9:0]  hlen_q, hlen_d, vlen_q, vlen_d;
    logic [3:0]  gf_q, gf_d, gf_inc;
    logic        h_started_q, h_started_d;
    logic [7:0]  pr_q, pg_q, pb_q;
    logic        pixel_valid_q, pixel_valid_d;
    logic        frame_start_q, frame_start_d;
    logic        locked_q, locked_d;
    logic        timing_err_q, timing_err_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        x_wrap, active, line_fail, blank_bad, err_inc;

    // Coordinate of the sample now in stage 1, plus the timing checks on it
    always_comb begin
        x_wrap = (x_q == X_LAST);
        x_d    = h_fall ? X_REF : (x_wrap ? 10'd0 : x_q + 10'd1);
        if (v_fall) begin
            y_d = Y_REF;
        end else if (!h_fall && x_wrap) begin
            y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
        end else begin
            y_d = y_q;
        end
        active    = (x_d < H_ACT) && (y_d < V_ACT);
        // Vertical and horizontal failures fold into one event so a
        // coincident double violation counts once
        line_fail = (v_fall && (vlen_q != V_LEN)) ||
                    (h_fall && h_started_q && (hlen_q != H_LEN)) ||
                    (hlen_q == LEN_SAT) || (vlen_q == LEN_SAT);
        blank_bad = (blank_s1_q != active);
        gf_inc    = gf_q + 4'd1;
    end

    // Lock FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEARCH: if (v_fall) state_d = VERIFY;
            VERIFY: begin
                if (line_fail)                        state_d = SEARCH;
                else if (v_fall && (gf_inc == LOCK_N)) state_d = LOCKED;
            end
            LOCKED: if (line_fail) state_d = SEARCH;
            default: state_d = SEARCH;
        endcase
    end

    // Line/frame length measurement and good-frame count
    always_comb begin
        hlen_d      = hlen_q;
        vlen_d      = vlen_q;
        gf_d        = gf_q;
        h_started_d = h_started_q;
        if (state_q == SEARCH) begin
            // A vsync edge restarts measurement; until then hold cleared
            h_started_d = v_fall && h_fall;
            hlen_d      = (v_fall && h_fall) ? 10'd1 : 10'd0;
            vlen_d      = (v_fall && h_fall) ? 10'd1 : 10'd0;
            gf_d        = 4'd0;
        end else if (line_fail) begin
            h_started_d = 1'b0;
            hlen_d      = 10'd0;
            vlen_d      = 10'd0;
            gf_d        = 4'd0;
        end else begin
            h_started_d = h_started_q | h_fall;
            hlen_d      = h_fall ? 10'd1 : len_inc(hlen_q);
            if (v_fall)      vlen_d = h_fall ? 10'd1 : 10'd0;
            else if (h_fall) vlen_d = len_inc(vlen_q);
            if (v_fall && (state_q == VERIFY)) gf_d = gf_inc;
        end
    end

    // Registered outputs, qualified by the lock state the sample lands in
    always_comb begin
        locked_d      = (state_d == LOCKED);
        pixel_valid_d = locked_d && active;
        frame_start_d = locked_d && (x_d == 10'd0) && (y_d == 10'd0);
        err_inc       = (state_q == LOCKED) && (line_fail || blank_bad);
        timing_err_d  = err_inc;
        err_count_d   = (err_inc && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
    end

    // Lock FSM state register
    always_ff @(posedge vgaclk) begin
        if (!reset_n) state_q <= SEARCH;
        else          state_q <= state_d;
    end

    // Stage-1 capture, measurement counters and output registers
    always_ff @(posedge vgaclk) begin
        if (!reset_n) begin
            r_s1_q        <= 8'd0;
            g_s1_q        <= 8'd0;
            b_s1_q        <= 8'd0;
            blank_s1_q    <= 1'b0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            hlen_q        <= 10'd0;
            vlen_q        <= 10'd0;
            gf_q          <= 4'd0;
            h_started_q   <= 1'b0;
            pr_q          <= 8'd0;
            pg_q          <= 8'd0;
            pb_q          <= 8'd0;
            pixel_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            timing_err_q  <= 1'b0;
            err_count_q   <= 8'd0;
        end else begin
            r_s1_q        <= r;
            g_s1_q        <= g;
            b_s1_q        <= b;
            blank_s1_q    <= blank_b;
            x_q           <= x_d;
            y_q           <= y_d;
            hlen_q        <= hlen_d;
            vlen_q        <= vlen_d;
            gf_q          <= gf_d;
            h_started_q   <= h_started_d;
            pr_q          <= r_s1_q;
            pg_q          <= g_s1_q;
            pb_q          <= b_s1_q;
            pixel_valid_q <= pixel_valid_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            timing_err_q  <= timing_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign pr          = pr_q;
    assign pg          = pg_q;
    assign pb          = pb_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign timing_err  = timing_err_q;
    assign err_count   = err_count_q;

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator: consumes hsync/vsync/blank_b/r/g/b as driven toward the monitor and recovers pixel coordinates.
- Measures line and frame lengths, locks after consecutive good frames and flags timing or blanking violations.
- Sits on the loopback/capture path for self-check of the video unit and as a front end for frame capture logic.

Parameters:
- HACTIVE, 640, active pixels per line.
- HFP, 16, horizontal front porch.
- HSYN, 96, hsync width.
- HBP, 48, horizontal back porch.
- VACTIVE, 480, active lines.
- VFP, 11, vertical front porch.
- VSYN, 2, vsync width.
- VBP, 32, vertical back porch.
- LOCK_FRAMES, 2, consecutive good frames required to assert locked (1..15).
- Derived, not overridable: HMAX = 800, VMAX = 525.

Ports:
- vgaclk  in  1  pixel clock.
- reset_n  in  1  synchronous active-low reset.
- hsync  in  1  active-low horizontal sync.
- vsync  in  1  active-low vertical sync.
- blank_b  in  1  high in active video.
- r, g, b  in  8 each  pixel colour.
- x, y  out  10 each  recovered coordinate of the pixel on pr/pg/pb.
- pr, pg, pb  out  8 each  pixel colour, delayed.
- pixel_valid  out  1  locked and (x < HACTIVE) and (y < VACTIVE).
- frame_start  out  1  one-cycle pulse with x=0, y=0 while locked.
- locked  out  1  timing lock.
- timing_err  out  1  one-cycle pulse on any detected violation.
- err_count  out  8  saturating violation count.

Behaviour:
- Reset (reset_n=0 at a vgaclk edge): all outputs 0, FSM=SEARCH, all counters 0, edge-detect history forced to 1 (idle high). This applies mid-frame too; no edge is detected on the first cycle after reset.
- Stage 1 registers all inputs. Edge detect compares stage 1 to stage 2, and falling edges are qualified from that.
- Outputs are registered from stage 1, giving a fixed latency of 2 vgaclk cycles from input to x/y/pr/pg/pb.
- Horizontal reference:
  - The hsync falling edge marks the sample at x = HACTIVE+HFP (656). The next sample is 657.
  - Otherwise x increments modulo HMAX.
- Vertical reference:
  - The vsync falling edge coincides with x=0 and marks y = VACTIVE+VFP (491).
  - Otherwise y increments modulo VMAX when x wraps 799->0.
- Measurement:
  - hlen counts cycles between hsync falling edges and saturates at 1023.
  - vlen counts hsync falling edges between vsync falling edges and saturates at 1023.
  - A line is good iff hlen == HMAX at the hsync edge. A frame is good iff vlen == VMAX at the vsync edge.
- FSM:
  - SEARCH: wait for a vsync falling edge; clear hlen, vlen and good_frames, then go to VERIFY. The first hsync edge after entry only starts hlen and is not checked.
  - VERIFY:
    - Bad line or bad frame: back to SEARCH, no timing_err.
    - Good frame: good_frames++; when good_frames reaches LOCK_FRAMES, go to LOCKED.
    - hlen or vlen saturating: back to SEARCH.
  - LOCKED:
    - Bad line, bad frame or saturation: timing_err pulse, err_count++, go to SEARCH, locked=0 on the next cycle.
    - Blanking check: blank_b must equal (x < HACTIVE and y < VACTIVE) each cycle. A mismatch gives a timing_err pulse and err_count++, but lock is kept.
- Simultaneous hsync and vsync edges:
  - Evaluate the vertical check first.
  - If both fail, a single error is counted (one timing_err pulse, err_count +1).
- err_count saturates at 255 and is cleared only by reset.
- x and y are still reported while unlocked (free-running from the last reference), but pixel_valid and frame_start stay 0.

Decomposition:
- Shared package vga_pkg holds the timing constants: HACTIVE, HFP, HSYN, HBP, VACTIVE, VFP, VSYN, VBP, HMAX, VMAX.
- vga_pkg also holds a 2-bit enum sync_state_t {SEARCH, VERIFY, LOCKED}.
- The existing vgaController is to import the same constants.
- One sub-module, sync_edge_det: a 2-flop sampler with a falling-edge pulse and a synchronous reset-to-1, instantiated for hsync and vsync.

Test Plan:
- Reset, then drive a clean generator model for 4 frames:
  - locked rises at the third vsync falling edge (1 sync + 2 good frames).
  - Exactly 307200 pixel_valid cycles per locked frame.
  - frame_start occurs with x=0, y=0, err_count=0.
- While locked, shorten one line to 799 cycles: one timing_err pulse, err_count=1, locked falls, and re-locks after two further clean frames.
- While locked, force blank_b=0 at x=10, y=10 for one cycle: timing_err pulse, err_count=1, locked stays 1.
- Hold vsync high for 2000 lines: vlen saturates, the FSM leaves the locked/verify state, locked=0. Recovery occurs on resumed clean frames.
- Assert reset_n=0 for one cycle mid-frame while locked: all outputs 0 the next cycle, no timing_err, lock reacquired after 2 clean frames.
- Pixel alignment: drive r = x[7:0] from the generator. Whenever pixel_valid=1, pr must equal x[7:0] of the output coordinate.
